// File: rtl/ex_mdu.sv
// ex_mdu: iterative RV32M multiply/divide unit that sits beside the EX ALU.
// Define MDU_EARLY_OUT_EN to let trivial operations (zero operands, divide by zero, overflow) skip the loop.
module ex_mdu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   r1_data_i,
  input  logic [XLEN-1:0]   r2_data_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              w_enable_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [XLEN-1:0]   w_data_o
);

  // state | meaning
  // IDLE  | waiting for start_i; operands decoded combinationally
  // CALC  | one shift-add or restoring-divide iteration per cycle
  // DONE  | sign-fixed result presented for one write-back beat

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              neg1_q, neg2_q, div0_q;
  logic [XLEN-1:0]   a_q, b_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   hold_data_q;
  logic [ADDR_W-1:0] hold_addr_q;

  logic              is_div, r1_signed, r2_signed, neg1, neg2;
  logic              in_div0, in_mul_zero, early, launch;
  logic [XLEN-1:0]   mag1, mag2;

  always_comb begin
    is_div      = op_i[2];
    r1_signed   = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
    r2_signed   = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
    neg1        = r1_signed && r1_data_i[XLEN-1];
    neg2        = r2_signed && r2_data_i[XLEN-1];
    mag1        = neg1 ? -r1_data_i : r1_data_i;
    mag2        = neg2 ? -r2_data_i : r2_data_i;
    in_div0     = is_div && (r2_data_i == '0);
    in_mul_zero = !is_div && ((r1_data_i == '0) || (r2_data_i == '0));
`ifdef MDU_EARLY_OUT_EN
    // Overflow skips the loop because the preloaded quotient (|MIN| = MIN) is already correct.
    early = in_div0 || in_mul_zero || (is_div && (r1_data_i == '0)) ||
            (is_div && !op_i[0] && (r1_data_i == MIN_VAL) && (r2_data_i == '1));
`else
    early = 1'b0;
`endif
  end

  // Shared accumulator: multiply keeps {product_hi, multiplier}, divide keeps {remainder, quotient}.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub, div_rem;
  logic              div_ge;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, b_q};
    div_sub   = div_shift[XLEN-1:0] - b_q;
    div_rem   = div_ge ? div_sub : div_shift[XLEN-1:0];
    if (op_q[2]) begin
      acc_step = {div_rem, acc_q[XLEN-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, result, data_now;

  always_comb begin
    prod_fix = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
    if (div0_q) begin
      // Divide by zero returns all ones and the untouched dividend.
      quot_fix = '1;
      rem_fix  = neg1_q ? -a_q : a_q;
    end else begin
      quot_fix = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end
    case (op_q)
      3'd0:          result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    result = quot_fix;
      default:       result = rem_fix;
    endcase
    data_now = (addr_q == '0) ? '0 : result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    stall_req_o = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    w_enable_o  = 1'b0;
    w_addr_o    = hold_addr_q;
    w_data_o    = hold_data_q;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          launch      = 1'b1;
          stall_req_o = 1'b1;
          state_d     = early ? DONE : CALC;
        end
      end
      CALC: begin
        busy_o      = 1'b1;
        stall_req_o = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_o     = 1'b1;
        done_o     = !flush_i;
        w_enable_o = !flush_i && (addr_q != '0);
        w_addr_o   = addr_q;
        w_data_o   = data_now;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      addr_q      <= '0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      div0_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      hold_data_q <= '0;
      hold_addr_q <= '0;
    end else begin
      if (launch) begin
        op_q   <= op_i;
        addr_q <= w_addr_i;
        neg1_q <= neg1;
        neg2_q <= neg2;
        div0_q <= in_div0;
        a_q    <= mag1;
        b_q    <= mag2;
        acc_q  <= in_mul_zero ? '0 : {{XLEN{1'b0}}, mag1};
        cnt_q  <= CNT_W'(XLEN);
      end else if (state_q == CALC) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if ((state_q == DONE) && !flush_i) begin
        hold_data_q <= data_now;
        hold_addr_q <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed and randomized check of ex_mdu against a plain-arithmetic RV32M reference.
module tb_ex_mdu;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [2:0]        op_i = '0;
  logic [XLEN-1:0]   r1_data_i = '0;
  logic [XLEN-1:0]   r2_data_i = '0;
  logic [ADDR_W-1:0] w_addr_i = '0;
  logic              flush_i = 1'b0;
  logic              stall_req_o, busy_o, done_o, w_enable_o;
  logic [ADDR_W-1:0] w_addr_o;
  logic [XLEN-1:0]   w_data_o;

  ex_mdu #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
    .r1_data_i(r1_data_i), .r2_data_i(r2_data_i), .w_addr_i(w_addr_i),
    .flush_i(flush_i), .stall_req_o(stall_req_o), .busy_o(busy_o),
    .done_o(done_o), .w_enable_o(w_enable_o), .w_addr_o(w_addr_o),
    .w_data_o(w_data_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic bit ref_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) return (b == 0) || (a == 0) || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF);
    return (a == 0) || (b == 0);
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = XLEN + 1;
`ifdef MDU_EARLY_OUT_EN
    if (ref_early(op, a, b)) lat = 1;
`else
    if (ref_early(op, a, b)) lat = XLEN + 1;
`endif
    return lat;
  endfunction

  // Reference pipeline view: at most one operation in flight, finishing on a known cycle.
  bit                m_active = 1'b0;
  int                m_done_cyc = 0;
  logic [31:0]       m_res = '0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [31:0]       h_data = '0;
  logic [ADDR_W-1:0] h_addr = '0;
  bit                h_known = 1'b1;
  bit                e_done, e_stall;
  int                done_seen = 0;
  int                last_done_cyc = -1;
  logic [31:0]       last_done_data = '0;
  logic              last_done_wen = 1'b0;
  logic [ADDR_W-1:0] last_done_addr = '0;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      e_done  = m_active && (cyc == m_done_cyc) && !flush_i;
      e_stall = m_active ? (cyc < m_done_cyc) : (start_i && !flush_i);
      chk("busy", busy_o, m_active);
      chk("stall", stall_req_o, e_stall);
      chk("done", done_o, e_done);
      chk("w_enable", w_enable_o, e_done && (m_addr != 0));
      if (e_done) begin
        chk("w_data", w_data_o, (m_addr == 0) ? 32'h0 : m_res);
        chk("w_addr", w_addr_o, m_addr);
      end else if (!m_active && h_known) begin
        chk("w_data_hold", w_data_o, h_data);
        chk("w_addr_hold", w_addr_o, h_addr);
      end
      if (done_o) begin
        done_seen++;
        last_done_cyc  = cyc;
        last_done_data = w_data_o;
        last_done_wen  = w_enable_o;
        last_done_addr = w_addr_o;
      end
      if (rst) begin
        m_active = 1'b0;
        h_data   = '0;
        h_addr   = '0;
        h_known  = 1'b1;
      end else if (m_active) begin
        if (cyc == m_done_cyc) begin
          if (!flush_i) begin
            h_data = (m_addr == 0) ? 32'h0 : m_res;
            h_addr = m_addr;
            h_known = 1'b1;
          end else begin
            h_known = 1'b0;
          end
          m_active = 1'b0;
        end else if (flush_i) begin
          m_active = 1'b0;
        end
      end else if (start_i && !flush_i) begin
        m_active   = 1'b1;
        m_res      = ref_result(op_i, r1_data_i, r2_data_i);
        m_addr     = w_addr_i;
        m_done_cyc = cyc + ref_latency(op_i, r1_data_i, r2_data_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [ADDR_W-1:0] wa);
    start_i   = 1'b1;
    op_i      = op;
    r1_data_i = a;
    r2_data_i = b;
    w_addr_i  = wa;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy_o && k < budget) begin
      tick();
      k++;
    end
    chk("idle_within_budget", busy_o, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          early;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0, d0;
    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0};
    vecs[8]  = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5,        1'b1};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1};

    repeat (3) tick();
    rst = 1'b0;
    chk("reset_done", done_o, 1'b0);
    chk("reset_wen", w_enable_o, 1'b0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_data", w_data_o, 32'h0);
    chk("reset_addr", w_addr_o, 5'd0);

    for (int i = 0; i < 12; i++) begin
      chk("model_pin", ref_result(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].exp);
    end

    for (int i = 0; i < 12; i++) begin
      c0 = cyc;
      launch(vecs[i].op, vecs[i].a, vecs[i].b, ADDR_W'(i + 1));
      wait_idle(40);
      chk("vec_data", last_done_data, vecs[i].exp);
      chk("vec_wen", last_done_wen, 1'b1);
      chk("vec_addr", last_done_addr, ADDR_W'(i + 1));
`ifdef MDU_EARLY_OUT_EN
      chk("vec_latency", last_done_cyc - c0, vecs[i].early ? 1 : 33);
`else
      chk("vec_latency", last_done_cyc - c0, 33);
`endif
      tick();
    end

    // Flush a divide mid-flight, then relaunch two cycles later.
    d0 = done_seen;
    c0 = cyc;
    launch(3'd4, 32'hFFFFFF9C, 32'd7, 5'd3);
    while (cyc < c0 + 10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_idle", busy_o, 1'b0);
    tick();
    launch(3'd5, 32'd1000, 32'd9, 5'd4);
    wait_idle(40);
    chk("flush_no_done", done_seen, d0 + 1);
    chk("relaunch_done_cyc", last_done_cyc, c0 + 45);
    chk("relaunch_data", last_done_data, 32'd111);

    // Synchronous reset mid-operation.
    d0 = done_seen;
    c0 = cyc;
    launch(3'd0, 32'd123, 32'd456, 5'd9);
    while (cyc < c0 + 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_stall", stall_req_o, 1'b0);
    chk("rst_data", w_data_o, 32'h0);
    chk("rst_addr", w_addr_o, 5'd0);
    repeat (40) tick();
    chk("rst_no_done", done_seen, d0);

    // Write to x0 is suppressed.
    launch(3'd0, 32'd3, 32'd4, 5'd0);
    wait_idle(40);
    chk("x0_wen", last_done_wen, 1'b0);
    chk("x0_data", last_done_data, 32'h0);

    // Start held through CALC: one launch, next one accepted the cycle after DONE.
    d0 = done_seen;
    c0 = cyc;
    start_i = 1'b1; op_i = 3'd3; r1_data_i = 32'd77; r2_data_i = 32'd5; w_addr_i = 5'd6;
    while (cyc < c0 + 34) tick();
    tick();
    start_i = 1'b0;
    chk("held_one_launch", done_seen, d0 + 1);
    wait_idle(40);
    chk("held_second_done", done_seen, d0 + 2);
    chk("held_second_cyc", last_done_cyc, c0 + 67);

    // Flush together with start in IDLE: flush wins.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; r1_data_i = 32'd2; r2_data_i = 32'd2;
    chk("flush_start_stall", stall_req_o, 1'b0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_start_busy", busy_o, 1'b0);

    for (int n = 0; n < 60; n++) begin
      start_i   = 1'b1;
      op_i      = 3'($urandom_range(0, 7));
      r1_data_i = pick();
      r2_data_i = pick();
      w_addr_i  = ADDR_W'($urandom_range(0, 31));
      flush_i   = ($urandom_range(0, 9) == 0);
      tick();
      start_i = 1'b0;
      flush_i = 1'b0;
      for (int k = 0; k < 40 && busy_o; k++) begin
        r1_data_i = $urandom;
        r2_data_i = $urandom;
        op_i      = 3'($urandom_range(0, 7));
        flush_i   = ($urandom_range(0, 24) == 0);
        rst       = ($urandom_range(0, 99) == 0);
        tick();
        flush_i = 1'b0;
        rst     = 1'b0;
      end
      chk("random_idle", busy_o, 1'b0);
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
